// File: rtl/lii_stream_pack_tx_if.sv
// Handshake bundle for the LII transmit packer: NLANE kernel lane streams in,
// one packed LII beat (with fixed src/dst tags) out.
interface lii_stream_pack_tx_if #(
  parameter int NLANE = 5,
  parameter int LW    = 17,
  parameter int PW    = 128
);
  logic [NLANE*LW-1:0] s_lane_tdata;
  logic [NLANE-1:0]    s_lane_tvalid;
  logic [NLANE-1:0]    s_lane_tready;
  logic [PW-1:0]       lii_out_p0_tdata;
  logic                lii_out_p0_tvalid;
  logic                lii_out_p0_tready;
  logic [7:0]          lii_out_p0_src;
  logic [7:0]          lii_out_p0_dst;

  // Environment side: drives the lane streams and the phy ready.
  modport master (
    output s_lane_tdata, s_lane_tvalid, lii_out_p0_tready,
    input  s_lane_tready, lii_out_p0_tdata, lii_out_p0_tvalid,
    input  lii_out_p0_src, lii_out_p0_dst
  );

  // Packer side: consumes the lane streams, produces the packed beat.
  modport slave (
    input  s_lane_tdata, s_lane_tvalid, lii_out_p0_tready,
    output s_lane_tready, lii_out_p0_tdata, lii_out_p0_tvalid,
    output lii_out_p0_src, lii_out_p0_dst
  );
endinterface

// File: rtl/lii_stream_pack_tx.sv
// Transmit-side LII packer. Each lane has a one-deep holding register so skewed
// lanes can arrive independently; once every lane holds a word they are packed
// together into a registered PW-bit output beat. Lane i occupies bits
// [i*LW +: LW]; bits above NLANE*LW are zero.
module lii_stream_pack_tx #(
  parameter int          NLANE  = 5,
  parameter int          LW     = 17,
  parameter int          PW     = 128,
  parameter logic [7:0]  SRC_ID = 8'h00,
  parameter logic [7:0]  DST_ID = 8'h01,
  parameter int          CNTW   = 16
) (
  input  logic                aclk,
  input  logic                arstn,
  lii_stream_pack_tx_if.slave bus,
  output logic [CNTW-1:0]     beat_count,
  output logic [NLANE-1:0]    lanes_pending
);

  if ((NLANE < 1) || (NLANE > 8)) begin : g_bad_nlane
    $fatal(1, "lii_stream_pack_tx: NLANE must be within 1..8");
  end
  if (NLANE * LW > PW) begin : g_bad_width
    $fatal(1, "lii_stream_pack_tx: NLANE*LW exceeds PW");
  end

  logic [NLANE-1:0] lane_full_reg;
  logic [LW-1:0]    lane_data_reg [NLANE];
  logic [NLANE-1:0] lane_ready;
  logic [NLANE-1:0] lane_cap;
  logic             out_valid_reg;
  logic [PW-1:0]    out_data_reg;
  logic [PW-1:0]    out_data_next;
  logic [CNTW-1:0]  cnt_reg;
  logic             out_free;
  logic             pack_fire;
  logic             out_hs;

  // The output register can take a new beat if it is empty or draining now.
  assign out_free   = ~out_valid_reg | bus.lii_out_p0_tready;
  assign pack_fire  = (&lane_full_reg) & out_free;
  // A full lane reopens in the same cycle it is packed, which is what keeps
  // the path at one beat per clock; this makes lane ready combinational
  // from the phy ready.
  assign lane_ready = ~lane_full_reg | {NLANE{pack_fire}};
  assign lane_cap   = bus.s_lane_tvalid & lane_ready;
  assign out_hs     = out_valid_reg & bus.lii_out_p0_tready;

  for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
    // Per-lane holding register: capture wins over the clear from packing.
    always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
        lane_full_reg[gi] <= 1'b0;
        lane_data_reg[gi] <= '0;
      end else if (lane_cap[gi]) begin
        lane_full_reg[gi] <= 1'b1;
        lane_data_reg[gi] <= bus.s_lane_tdata[gi*LW +: LW];
      end else if (pack_fire) begin
        lane_full_reg[gi] <= 1'b0;
      end
    end
  end

  // Assemble the packed beat from the held lane words, zero-filling the top.
  always_comb begin
    out_data_next = '0;
    for (int i = 0; i < NLANE; i++) begin
      out_data_next[i*LW +: LW] = lane_data_reg[i];
    end
  end

  // Registered output stage; holds steady while the phy stalls.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (pack_fire) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= out_data_next;
    end else if (out_hs) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Count beats accepted by the phy, wrapping at 2^CNTW.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      cnt_reg <= '0;
    end else if (out_hs) begin
      cnt_reg <= cnt_reg + CNTW'(1);
    end
  end

  assign bus.s_lane_tready     = lane_ready;
  assign bus.lii_out_p0_tdata  = out_data_reg;
  assign bus.lii_out_p0_tvalid = out_valid_reg;
  assign bus.lii_out_p0_src    = SRC_ID;
  assign bus.lii_out_p0_dst    = DST_ID;
  assign beat_count            = cnt_reg;
  assign lanes_pending         = lane_full_reg;

endmodule

// File: tb/tb_lii_stream_pack_tx.sv
// Bench for lii_stream_pack_tx. Accepted lane words go into per-lane queues;
// the k-th packed beat is the k-th accepted word of every lane, pushed onto an
// expected-beat queue and checked by a monitor when the phy takes a beat.
module tb_lii_stream_pack_tx;
  localparam int NLANE = 5;
  localparam int LW    = 17;
  localparam int PW    = 128;

  logic aclk = 1'b0;
  logic arstn;
  logic [15:0]      beat_count;
  logic [NLANE-1:0] lanes_pending;
  logic [3:0]       beat_count4;
  logic [NLANE-1:0] lanes_pending4;

  lii_stream_pack_tx_if #(.NLANE(NLANE), .LW(LW), .PW(PW)) bus ();
  lii_stream_pack_tx_if #(.NLANE(NLANE), .LW(LW), .PW(PW)) bus4 ();

  lii_stream_pack_tx #(.NLANE(NLANE), .LW(LW), .PW(PW), .SRC_ID(8'h00),
                       .DST_ID(8'h01), .CNTW(16)) dut (
    .aclk(aclk), .arstn(arstn), .bus(bus),
    .beat_count(beat_count), .lanes_pending(lanes_pending));

  // Second copy with a 4-bit counter, fed identical stimulus, for wrap checks.
  lii_stream_pack_tx #(.NLANE(NLANE), .LW(LW), .PW(PW), .SRC_ID(8'h00),
                       .DST_ID(8'h01), .CNTW(4)) dut4 (
    .aclk(aclk), .arstn(arstn), .bus(bus4),
    .beat_count(beat_count4), .lanes_pending(lanes_pending4));

  assign bus4.s_lane_tdata      = bus.s_lane_tdata;
  assign bus4.s_lane_tvalid     = bus.s_lane_tvalid;
  assign bus4.lii_out_p0_tready = bus.lii_out_p0_tready;

  initial forever #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard state
  logic [LW-1:0] lane_q [NLANE][$];
  logic [PW-1:0] exp_q [$];
  logic [31:0]   hs_count;
  logic          prev_stall;
  logic [PW-1:0] prev_data;

  // Monitor: model input acceptance and check every output handshake.
  initial begin
    hs_count   = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge aclk);
      if (!arstn) begin
        for (int i = 0; i < NLANE; i++) lane_q[i].delete();
        exp_q.delete();
        hs_count   = 0;
        prev_stall = 1'b0;
      end else begin
        check("beat_count", PW'(beat_count), PW'(hs_count[15:0]));
        check("beat_count_w4", PW'(beat_count4), PW'(hs_count[3:0]));
        if (hs_count == 17) check("cnt4_after_17", PW'(beat_count4), PW'(1));
        check("src_dst", PW'({bus.lii_out_p0_src, bus.lii_out_p0_dst}), PW'(16'h0001));
        if (prev_stall) begin
          check("stall_valid", PW'(bus.lii_out_p0_tvalid), PW'(1));
          check("stall_data", bus.lii_out_p0_tdata, prev_data);
        end
        if (bus.lii_out_p0_tvalid && bus.lii_out_p0_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", bus.lii_out_p0_tdata, 'x);
          end else begin
            logic [PW-1:0] e;
            e = exp_q.pop_front();
            $display("beat %0d: data=%h expected=%h", hs_count, bus.lii_out_p0_tdata, e);
            check("beat_data", bus.lii_out_p0_tdata, e);
          end
          hs_count++;
        end
        prev_stall = bus.lii_out_p0_tvalid & ~bus.lii_out_p0_tready;
        prev_data  = bus.lii_out_p0_tdata;
        for (int i = 0; i < NLANE; i++)
          if (bus.s_lane_tvalid[i] && bus.s_lane_tready[i])
            lane_q[i].push_back(bus.s_lane_tdata[i*LW +: LW]);
        forever begin
          logic [PW-1:0] b;
          logic all_have;
          all_have = 1'b1;
          for (int i = 0; i < NLANE; i++) if (lane_q[i].size() == 0) all_have = 1'b0;
          if (!all_have) break;
          b = '0;
          for (int i = 0; i < NLANE; i++) b[i*LW +: LW] = lane_q[i].pop_front();
          exp_q.push_back(b);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [PW-1:0]    exp_beat;
    logic [PW-1:0]    held;
    logic [NLANE-1:0] acc;
    int               run;

    arstn = 1'b0;
    bus.s_lane_tdata      = '0;
    bus.s_lane_tvalid     = '0;
    bus.lii_out_p0_tready = 1'b0;

    // Reset held low with random inputs
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.s_lane_tvalid     = NLANE'($urandom);
      bus.s_lane_tdata      = {$urandom, $urandom, $urandom};
      bus.lii_out_p0_tready = 1'($urandom);
      @(negedge aclk);
      check("rst_tvalid", PW'(bus.lii_out_p0_tvalid), PW'(0));
      check("rst_lane_tready", PW'(bus.s_lane_tready), PW'(5'b11111));
      check("rst_beat_count", PW'(beat_count), PW'(0));
      check("rst_tdata", bus.lii_out_p0_tdata, PW'(0));
    end
    tick();
    bus.s_lane_tvalid     = '0;
    bus.s_lane_tdata      = '0;
    bus.lii_out_p0_tready = 1'b1;
    arstn = 1'b1;

    // Directed skewed arrival: lane i presents i+1 in cycle i
    for (int i = 0; i < NLANE; i++) begin
      tick();
      bus.s_lane_tvalid = NLANE'(1) << i;
      bus.s_lane_tdata  = '0;
      bus.s_lane_tdata[i*LW +: LW] = LW'(i + 1);
      if (i == NLANE - 1) begin
        @(negedge aclk);
        check("skew_lane_tready", PW'(bus.s_lane_tready), PW'(5'b10000));
      end
    end
    tick();
    bus.s_lane_tvalid = '0;
    @(negedge aclk);
    check("lat_capture_edge", PW'(bus.lii_out_p0_tvalid), PW'(0));
    tick();
    @(negedge aclk);
    check("lat_pack_edge", PW'(bus.lii_out_p0_tvalid), PW'(1));
    exp_beat = '0;
    exp_beat[NLANE*LW-1:0] = {17'd5, 17'd4, 17'd3, 17'd2, 17'd1};
    check("directed_tdata", bus.lii_out_p0_tdata, exp_beat);
    tick();
    @(negedge aclk);
    check("directed_count", PW'(beat_count), PW'(1));

    // Full-rate streaming for 100 cycles
    run = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      bus.s_lane_tvalid = '1;
      for (int i = 0; i < NLANE; i++) bus.s_lane_tdata[i*LW +: LW] = LW'(c * NLANE + i);
      @(negedge aclk);
      if (bus.lii_out_p0_tvalid) run++;
    end
    tick();
    bus.s_lane_tvalid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      if (bus.lii_out_p0_tvalid) run++;
      tick();
    end
    check("stream_beats", PW'(run), PW'(100));

    // Backpressure with two packs pending
    bus.lii_out_p0_tready = 1'b0;
    bus.s_lane_tvalid     = '1;
    bus.s_lane_tdata      = {$urandom, $urandom, $urandom};
    tick();
    bus.s_lane_tdata      = {$urandom, $urandom, $urandom};
    tick();
    bus.s_lane_tdata      = {$urandom, $urandom, $urandom};
    @(negedge aclk);
    held = bus.lii_out_p0_tdata;
    for (int k = 0; k < 10; k++) begin
      check("bp_hold_data", bus.lii_out_p0_tdata, held);
      if (k == 9) begin
        check("bp_lanes_pending", PW'(lanes_pending), PW'(5'b11111));
        check("bp_lane_tready", PW'(bus.s_lane_tready), PW'(0));
      end
      tick();
      @(negedge aclk);
    end
    tick();
    bus.lii_out_p0_tready = 1'b1;
    tick();
    bus.s_lane_tvalid = '0;
    repeat (5) tick();

    // Reset mid-operation: 3 lanes full and a beat pending
    bus.lii_out_p0_tready = 1'b0;
    bus.s_lane_tvalid     = '1;
    bus.s_lane_tdata      = {$urandom, $urandom, $urandom};
    tick();
    bus.s_lane_tvalid     = 5'b00111;
    bus.s_lane_tdata      = {$urandom, $urandom, $urandom};
    tick();
    bus.s_lane_tvalid     = '0;
    @(negedge aclk);
    check("mid_setup_tvalid", PW'(bus.lii_out_p0_tvalid), PW'(1));
    check("mid_setup_pending", PW'(lanes_pending), PW'(5'b00111));
    #1 arstn = 1'b0;
    #1 check("async_rst_tvalid", PW'(bus.lii_out_p0_tvalid), PW'(0));
    repeat (2) tick();
    arstn = 1'b1;
    @(negedge aclk);
    check("post_rst_pending", PW'(lanes_pending), PW'(0));
    tick();
    bus.lii_out_p0_tready = 1'b1;
    bus.s_lane_tvalid     = '1;
    bus.s_lane_tdata      = {$urandom, $urandom, $urandom};
    tick();
    bus.s_lane_tvalid     = '0;
    repeat (4) tick();
    check("post_rst_count", PW'(beat_count), PW'(1));

    // Randomized skew and backpressure
    for (int c = 0; c < 600; c++) begin
      @(negedge aclk);
      acc = bus.s_lane_tvalid & bus.s_lane_tready;
      tick();
      for (int i = 0; i < NLANE; i++) begin
        if (!bus.s_lane_tvalid[i] || acc[i]) begin
          bus.s_lane_tvalid[i] = ($urandom_range(0, 3) != 0);
          bus.s_lane_tdata[i*LW +: LW] = LW'($urandom);
        end
      end
      bus.lii_out_p0_tready = ($urandom_range(0, 3) != 0);
    end
    @(negedge aclk);
    tick();
    bus.s_lane_tvalid     = '0;
    bus.lii_out_p0_tready = 1'b1;
    repeat (10) tick();
    check("drain_empty", PW'(exp_q.size()), PW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
